// File: rtl/graph_mem_pkg.sv
// rtl/graph_mem_pkg.sv - shared types and constants for the graph memory arbiter
package graph_mem_pkg;
  localparam int NUM_REQ_DEFAULT = 2;
  localparam int MEM_DATA_W      = 32;

  typedef logic [$clog2(NUM_REQ_DEFAULT)-1:0] req_id_t;
endpackage

// File: rtl/graph_mem_arbiter_if.sv
// rtl/graph_mem_arbiter_if.sv - requester and graph_memory signals of one arbiter instance
interface graph_mem_arbiter_if
  import graph_mem_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = MEM_DATA_W,
  parameter int DEPTH      = 4
);
  logic [NUM_REQ-1:0]      req_valid_in;
  logic [ADDR_WIDTH-1:0]   req_addr_in [NUM_REQ];
  logic [NUM_REQ-1:0]      gnt_out;
  logic [NUM_REQ-1:0]      resp_valid_out;
  logic [DATA_WIDTH-1:0]   resp_data_out;
  logic                    mem_valid_out;
  logic [ADDR_WIDTH-1:0]   mem_req_out;
  logic                    mem_valid_in;
  logic [DATA_WIDTH-1:0]   mem_data_in;
  logic [$clog2(DEPTH):0]  occupancy_out;
  logic                    err_out;

  modport master (
    input  req_valid_in, req_addr_in, mem_valid_in, mem_data_in,
    output gnt_out, resp_valid_out, resp_data_out, mem_valid_out, mem_req_out,
           occupancy_out, err_out
  );

  modport slave (
    output req_valid_in, req_addr_in, mem_valid_in, mem_data_in,
    input  gnt_out, resp_valid_out, resp_data_out, mem_valid_out, mem_req_out,
           occupancy_out, err_out
  );
endinterface

// File: rtl/graph_mem_arbiter_tag_fifo.sv
// rtl/graph_mem_arbiter_tag_fifo.sv - in-order FIFO of requester ids for outstanding reads
module tag_fifo
  import graph_mem_pkg::*;
#(
  parameter int WIDTH = $bits(req_id_t),
  parameter int DEPTH = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push_in,
  input  logic [WIDTH-1:0]       push_data_in,
  input  logic                   pop_in,
  output logic [WIDTH-1:0]       head_out,
  output logic [$clog2(DEPTH):0] count_out,
  output logic                   full_out,
  output logic                   empty_out
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_out  = (count_q == CNT_W'(DEPTH));
  assign empty_out = (count_q == '0);
  assign count_out = count_q;
  assign head_out  = store_q[rd_ptr_q];

  always_comb begin
    do_push  = push_in && !full_out;
    do_pop   = pop_in && !empty_out;
    // Pointers wrap naturally at DEPTH (power of two); count tells full from empty.
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      store_q[wr_ptr_q] <= push_data_in;
    end
  end
endmodule

// File: rtl/graph_mem_arbiter.sv
// rtl/graph_mem_arbiter.sv - round-robin sharing of one graph_memory read port among requesters
module graph_mem_arbiter
  import graph_mem_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = MEM_DATA_W,
  parameter int DEPTH      = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  graph_mem_arbiter_if.master bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [ADDR_WIDTH-1:0] mem_req_q, mem_req_d;
  logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  err_q, err_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       win_id, scan_id, head_id;
  logic [ID_W:0]         scan_sum;
  logic                  win_found, push, pop;
  logic [CNT_W-1:0]      count;
  logic                  full, empty;

  tag_fifo #(.WIDTH(ID_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .push_in      (push),
    .push_data_in (win_id),
    .pop_in       (pop),
    .head_out     (head_id),
    .count_out    (count),
    .full_out     (full),
    .empty_out    (empty)
  );

  // Scan from ptr cyclically; a full tag FIFO blocks grants even if a pop lands this cycle.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_sum  = '0;
    scan_id   = '0;
    gnt       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end
      scan_id = scan_sum[ID_W-1:0];
      if (!win_found && bus.req_valid_in[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
    if (!rst_in && !full && win_found) begin
      gnt[win_id] = 1'b1;
    end
  end

  always_comb begin
    push         = |gnt;
    pop          = bus.mem_valid_in && !empty;
    mem_valid_d  = push;
    mem_req_d    = mem_req_q;
    ptr_d        = ptr_q;
    if (push) begin
      mem_req_d = bus.req_addr_in[win_id];
      ptr_d     = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
    end
    resp_valid_d = pop ? (NUM_REQ'(1) << head_id) : '0;
    resp_data_d  = pop ? bus.mem_data_in : resp_data_q;
    err_d        = err_q || (bus.mem_valid_in && empty);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_req_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      mem_valid_q  <= mem_valid_d;
      mem_req_q    <= mem_req_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  assign bus.gnt_out        = gnt;
  assign bus.mem_valid_out  = mem_valid_q;
  assign bus.mem_req_out    = mem_req_q;
  assign bus.resp_valid_out = resp_valid_q;
  assign bus.resp_data_out  = resp_data_q;
  assign bus.occupancy_out  = count;
  assign bus.err_out        = err_q;
endmodule

// File: tb/tb_graph_mem_arbiter.sv
// tb/tb_graph_mem_arbiter.sv - self-checking bench for graph_mem_arbiter
module tb_graph_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  graph_mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) bus ();

  graph_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: outstanding ids as a queue, registered outputs predicted one edge ahead.
  int             tags[$];
  int             mptr = 0;
  int             g;
  int             id;
  bit             model_on = 1'b0;
  logic [N-1:0]   model_gnt;
  logic           exp_mem_valid = 1'b0;
  logic [AW-1:0]  exp_mem_req = '0;
  logic [N-1:0]   exp_resp_valid = '0;
  logic [DW-1:0]  exp_resp_data = '0;
  logic           exp_err = 1'b0;
  int             exp_occ = 0;

  logic [N-1:0]   last_gnt = '0;
  logic           mem_seen = 1'b0;
  logic [AW-1:0]  mem_seen_addr = '0;

  always @(negedge clk) begin
    last_gnt      = bus.gnt_out;
    mem_seen      = bus.mem_valid_out;
    mem_seen_addr = bus.mem_req_out;
    if (model_on) begin
      chk("mem_valid_out", bus.mem_valid_out, exp_mem_valid);
      chk("mem_req_out", bus.mem_req_out, exp_mem_req);
      chk("resp_valid_out", bus.resp_valid_out, exp_resp_valid);
      chk("resp_data_out", bus.resp_data_out, exp_resp_data);
      chk("err_out", bus.err_out, exp_err);
      chk("occupancy_out", bus.occupancy_out, exp_occ);
      if (rst) begin
        chk("gnt_in_reset", bus.gnt_out, '0);
        tags.delete();
        mptr           = 0;
        exp_mem_valid  = 1'b0;
        exp_mem_req    = '0;
        exp_resp_valid = '0;
        exp_resp_data  = '0;
        exp_err        = 1'b0;
        exp_occ        = 0;
      end else begin
        model_gnt = '0;
        g = -1;
        if (tags.size() < D) begin
          for (int k = 0; k < N; k++) begin
            if (g < 0 && bus.req_valid_in[(mptr + k) % N]) g = (mptr + k) % N;
          end
        end
        if (g >= 0) model_gnt[g] = 1'b1;
        chk("gnt_out", bus.gnt_out, model_gnt);
        exp_resp_valid = '0;
        if (bus.mem_valid_in) begin
          if (tags.size() > 0) begin
            id = tags.pop_front();
            exp_resp_valid = N'(1) << id;
            exp_resp_data  = bus.mem_data_in;
          end else begin
            exp_err = 1'b1;
          end
        end
        exp_mem_valid = (g >= 0);
        if (g >= 0) begin
          tags.push_back(g);
          exp_mem_req = bus.req_addr_in[g];
          mptr = (g + 1) % N;
        end
        exp_occ = tags.size();
      end
    end
  end

  // Requester queues and a fixed-latency memory model.
  logic [AW-1:0] rq0[$];
  logic [AW-1:0] rq1[$];
  logic [AW-1:0] pend_addr[$];
  int            pend_due[$];
  int            cyc = 0;
  int            lat = 2;
  bit            mem_en = 1'b1;
  int            mem_budget = -1;
  bit            inj = 1'b0;

  task automatic step();
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    cyc++;
    if (last_gnt[0] && rq0.size() > 0) void'(rq0.pop_front());
    if (last_gnt[1] && rq1.size() > 0) void'(rq1.pop_front());
    bus.req_valid_in[0] = (rq0.size() > 0);
    bus.req_addr_in[0]  = (rq0.size() > 0) ? rq0[0] : '0;
    bus.req_valid_in[1] = (rq1.size() > 0);
    bus.req_addr_in[1]  = (rq1.size() > 0) ? rq1[0] : '0;
    if (!rst && mem_seen) begin
      pend_addr.push_back(mem_seen_addr);
      pend_due.push_back(cyc - 1 + lat);
    end
    bus.mem_valid_in = 1'b0;
    bus.mem_data_in  = '0;
    if (inj) begin
      bus.mem_valid_in = 1'b1;
      bus.mem_data_in  = 32'hDEAD;
      inj = 1'b0;
    end else if (mem_en && mem_budget != 0 && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      a = pend_addr.pop_front();
      void'(pend_due.pop_front());
      bus.mem_valid_in = 1'b1;
      bus.mem_data_in  = a + 32'h9A;
      if (mem_budget > 0) mem_budget--;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq0.delete();
    rq1.delete();
    step();
    step();
    pend_addr.delete();
    pend_due.delete();
    rst = 1'b0;
  endtask

  task automatic wait_resp(input string nm, input logic [N-1:0] who, input logic [DW-1:0] data);
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      #2;
      if (bus.resp_valid_out != '0) begin
        found = 1'b1;
        chk({nm, "_valid"}, bus.resp_valid_out, who);
        chk({nm, "_data"}, bus.resp_data_out, data);
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_response required=%0h", nm, who);
    end
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((rq0.size() > 0 || rq1.size() > 0 || pend_addr.size() > 0 || tags.size() > 0) && k < 60) begin
      step();
      k++;
    end
    step();
    step();
    checks++;
    if (k >= 60) begin
      failures++;
      $display("FAIL %s_drain actual=busy required=idle", nm);
    end
  endtask

  logic [N-1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    bus.req_valid_in = '0;
    bus.req_addr_in[0] = '0;
    bus.req_addr_in[1] = '0;
    bus.mem_valid_in = 1'b0;
    bus.mem_data_in  = '0;
    step();
    step();
    model_on = 1'b1;
    do_reset();
    #2;
    chk("reset_occupancy", bus.occupancy_out, 0);
    chk("reset_mem_valid", bus.mem_valid_out, 0);

    // Single request, latency 2, data 0x10 + 0x9A = 0xAA.
    rq0.push_back(32'h10);
    step(); #2;
    chk("t1_gnt", bus.gnt_out, 2'b01);
    step(); #2;
    chk("t1_mem_valid", bus.mem_valid_out, 1);
    chk("t1_mem_req", bus.mem_req_out, 32'h10);
    wait_resp("t1_resp", 2'b01, 32'hAA);
    drain("t1");

    // Both requesting from ptr=0: alternate grants, responses routed in order.
    do_reset();
    rq0.push_back(32'h20); rq0.push_back(32'h40);
    rq1.push_back(32'h30); rq1.push_back(32'h50);
    for (int k = 0; k < 4; k++) begin
      step(); #2;
      chk($sformatf("t2_gnt%0d", k), bus.gnt_out, exp_seq[k]);
    end
    wait_resp("t2_resp0", 2'b01, 32'hBA);
    wait_resp("t2_resp1", 2'b10, 32'hCA);
    drain("t2");

    // Stalled memory fills the tag FIFO; one response frees exactly one slot next cycle.
    do_reset();
    mem_en = 1'b0;
    for (int k = 0; k < 6; k++) rq0.push_back(32'h100 + 32'(k * 4));
    for (int k = 0; k < 4; k++) step();
    step(); #2;
    chk("t3_full_gnt", bus.gnt_out, 0);
    chk("t3_full_occ", bus.occupancy_out, 4);
    step(); #2;
    chk("t3_still_full_gnt", bus.gnt_out, 0);
    mem_en = 1'b1;
    mem_budget = 1;
    step(); #2;
    chk("t3_nobypass_gnt", bus.gnt_out, 0);
    chk("t3_nobypass_occ", bus.occupancy_out, 4);
    step(); #2;
    chk("t3_regrant_gnt", bus.gnt_out, 2'b01);
    chk("t3_regrant_occ", bus.occupancy_out, 3);
    mem_budget = -1;
    drain("t3");

    // Spurious response sets the sticky error; traffic still flows afterwards.
    inj = 1'b1;
    step();
    step(); #2;
    chk("t4_err", bus.err_out, 1);
    chk("t4_resp_valid", bus.resp_valid_out, 0);
    rq1.push_back(32'h60);
    wait_resp("t4_resp", 2'b10, 32'hFA);
    chk("t4_err_sticky", bus.err_out, 1);
    drain("t4");

    // Latency 1 with a continuous stream: push and pop together hold occupancy at 2.
    do_reset();
    lat = 1;
    for (int k = 0; k < 6; k++) rq0.push_back(32'h200 + 32'(k * 4));
    step(); step(); step(); #2;
    chk("t5_occ_before", bus.occupancy_out, 2);
    chk("t5_gnt", bus.gnt_out, 2'b01);
    step(); #2;
    chk("t5_occ_after", bus.occupancy_out, 2);
    drain("t5");
    lat = 2;

    // Reset with three reads outstanding clears everything; ptr back to 0.
    do_reset();
    mem_en = 1'b0;
    for (int k = 0; k < 3; k++) rq0.push_back(32'h300 + 32'(k * 4));
    step(); step(); step(); step(); #2;
    chk("t6_occ_pre", bus.occupancy_out, 3);
    do_reset();
    #2;
    chk("t6_occ", bus.occupancy_out, 0);
    chk("t6_mem_valid", bus.mem_valid_out, 0);
    chk("t6_mem_req", bus.mem_req_out, 0);
    chk("t6_resp_valid", bus.resp_valid_out, 0);
    chk("t6_err", bus.err_out, 0);
    mem_en = 1'b1;
    rq1.push_back(32'h70);
    step(); #2;
    chk("t6_gnt", bus.gnt_out, 2'b10);
    wait_resp("t6_resp", 2'b10, 32'h10A);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/graph_mem_arbiter.md
Name: graph_mem_arbiter

Overview:
Shares one graph_memory read port among NUM_REQ graph_fetch/bfis requesters (one per processing element). Each cycle it picks one pending request by round-robin and issues it to memory. It records the winner's ID in an in-order tag FIFO. When the memory response returns, it routes the data back to the requester that issued the read. It sits between the per-PE fetch units and graph_memory port A or B; one instance is used per memory port.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, memory word width
DEPTH, 4, max outstanding reads (tag FIFO depth, power of 2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
req_valid_in  input  [NUM_REQ-1:0]  request pending per requester; held high with address stable until granted
req_addr_in  input  [ADDR_WIDTH-1:0] x NUM_REQ (unpacked)  read address per requester
gnt_out  output  [NUM_REQ-1:0]  one-hot grant, combinational, same cycle as acceptance
resp_valid_out  output  [NUM_REQ-1:0]  one-hot response strobe, 1 cycle
resp_data_out  output  DATA_WIDTH  response data, broadcast to all requesters
mem_valid_out  output  1  read strobe to graph_memory
mem_req_out  output  ADDR_WIDTH  read address to graph_memory
mem_valid_in  input  1  read data valid from graph_memory
mem_data_in  input  DATA_WIDTH  read data from graph_memory
occupancy_out  output  $clog2(DEPTH)+1  reads currently outstanding
err_out  output  1  sticky: response arrived with no outstanding tag

Behaviour:
- Reset values: all registered outputs are 0. That covers mem_valid_out, mem_req_out, resp_valid_out, resp_data_out, occupancy_out and err_out. Priority pointer ptr=0, tag FIFO empty. gnt_out is 0 while rst_in is high.
- Reset mid-operation discards every outstanding tag. graph_memory shares rst_in, so no stale responses are expected. Any response that arrives with the FIFO empty sets err_out.
- Arbitration (combinational):
  - can_issue = (count < DEPTH).
  - If can_issue, grant the first i with req_valid_in[i]=1, scanning ptr, ptr+1, ... cyclically mod NUM_REQ. gnt_out has at most one bit set.
  - If count == DEPTH, gnt_out = 0, even if a pop happens in the same cycle. No bypass.
- Grant cycle (winner g):
  - Registered: mem_valid_out <= 1, mem_req_out <= req_addr_in[g], ptr <= (g+1) mod NUM_REQ.
  - g is pushed into the tag FIFO.
  - With no grant: mem_valid_out <= 0, mem_req_out holds, ptr holds.
- Requester side: a requester sees gnt_out[i]=1 and may present its next request in the following cycle. Back-to-back grants to the same requester are legal when it is the only one requesting.
- Response path:
  - On mem_valid_in with FIFO non-empty: pop head id. Registered: resp_data_out <= mem_data_in, resp_valid_out <= (1 << id).
  - On mem_valid_in with FIFO empty: err_out <= 1 (sticky until reset), resp_valid_out <= 0, data dropped.
- Responses are assumed in issue order; graph_memory is fixed-latency.
- Latency: grant cycle T gives mem_valid_out at T+1. Memory response at cycle M gives resp_valid_out at M+1.
- Counter: count += push, -= pop. A simultaneous push and pop leaves it unchanged. occupancy_out = count, registered.
- FIFO pointers wrap mod DEPTH; full and empty are distinguished by count.
- Fairness: every continuously asserted request is granted within NUM_REQ grant opportunities.

Decomposition:
- Package graph_mem_pkg holds:
  - typedef req_id_t = logic [$clog2(NUM_REQ)-1:0], with the default NUM_REQ given as a package constant;
  - localparam MEM_DATA_W = 32.
- One sub-module is natural: tag_fifo, a synchronous FIFO of req_id_t with push, pop, count, full and empty. The arbiter and routing logic stay in the top module.

Test Plan:
- Single requester 0, addr 0x10; memory model with latency 2 returns 0xAA. Expect gnt_out=01 at T, mem_valid_out/mem_req_out=0x10 at T+1, resp_valid_out=01 with resp_data_out=0xAA one cycle after mem_valid_in.
- Both requesters held high for 4 cycles, ptr=0. Expect grants 01,10,01,10 and responses routed in the same order, each with the correct data.
- Memory stalled (no responses), requester 0 continuous, DEPTH=4. Expect exactly 4 grants, then gnt_out=0 with occupancy_out=4. The first response gives one new grant in the following cycle.
- mem_valid_in pulsed with no outstanding read. Expect err_out=1 that stays set, resp_valid_out stays 0, and the next legal transaction still completes.
- Grant and response in the same cycle with occupancy_out=2. Expect occupancy_out to stay at 2.
- rst_in asserted with 3 reads outstanding. Expect all outputs 0, occupancy_out=0, ptr=0, and that the next request from requester 1 alone is granted first.
